// File: rtl/microm_regstack_unit_if.sv
// Command/response bundle between the microm decoder (master) and the
// register/stack execution unit (slave).
interface microm_regstack_unit_if #(
   parameter int WIDTH = 32,
   parameter int RW    = 3
);
   logic             op_valid;
   logic             op_ready;
   logic [3:0]       op_code;
   logic [RW-1:0]    op_rd;
   logic [RW-1:0]    op_rs;
   logic [WIDTH-1:0] op_imm;
   logic             done;
   logic             err;
   logic [1:0]       err_code;

   modport master (
      output op_valid, op_code, op_rd, op_rs, op_imm,
      input  op_ready, done, err, err_code
   );

   modport slave (
      input  op_valid, op_code, op_rd, op_rs, op_imm,
      output op_ready, done, err, err_code
   );
endinterface

// File: rtl/microm_regstack_unit.sv
// microm register/stack execution unit: register file, operand stack in a
// registered-read RAM, two-state sequencer. SWAP is built only with MICROM_REGSTACK_SWAP_EN.
module microm_regstack_unit #(
   parameter int  WIDTH = 32,
   parameter int  NREG  = 8,
   parameter int  DEPTH = 16,
   localparam int RW    = $clog2(NREG),
   localparam int SW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   microm_regstack_unit_if.slave  cmd,
   input  logic [RW-1:0]          rd_addr,
   output logic [WIDTH-1:0]       rd_data,
   output logic [SW:0]            sp
);
`ifdef MICROM_REGSTACK_SWAP_EN
   localparam bit SWAP_EN = 1'b1;
`else
   localparam bit SWAP_EN = 1'b0;
`endif

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MOVI  = 4'd1;
   localparam logic [3:0] OP_PUSH  = 4'd2;
   localparam logic [3:0] OP_POP   = 4'd3;
   localparam logic [3:0] OP_DUP   = 4'd4;
   localparam logic [3:0] OP_RCOPY = 4'd5;
   localparam logic [3:0] OP_RMOV  = 4'd6;
   localparam logic [3:0] OP_SWAP  = 4'd7;
   localparam logic [SW:0] SP_FULL = (SW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_RD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [SW:0]      sp_q, sp_d, sp_m1;
   logic [3:0]       code_q, code_d;
   logic [RW-1:0]    rd_q, rd_d;
   logic             done_q, done_d, err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_rdata_q;
   logic [SW-1:0]    ram_addr;
   logic             ram_we, ram_re;
   logic [WIDTH-1:0] ram_wdata;

   logic accept, stack_rd_op, underflow, overflow, illegal, fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sp_q       <= '0;
         code_q     <= OP_NOP;
         rd_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         code_q     <= code_d;
         rd_q       <= rd_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Single-port stack RAM: one address per cycle, contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata_q <= mem[ram_addr];
   end

   always_comb begin
      accept      = cmd.op_valid && (state_q == S_IDLE);
      stack_rd_op = (cmd.op_code == OP_POP) || (cmd.op_code == OP_DUP) ||
                    ((cmd.op_code == OP_SWAP) && SWAP_EN);
      underflow   = stack_rd_op && (sp_q == '0);
      overflow    = ((cmd.op_code == OP_PUSH) || (cmd.op_code == OP_DUP)) && (sp_q == SP_FULL);
      illegal     = cmd.op_code[3] || ((cmd.op_code == OP_SWAP) && !SWAP_EN);
      fault       = underflow || overflow || illegal;
      sp_m1       = sp_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == S_RD)
         state_d = S_IDLE;
      else if (accept && stack_rd_op && !fault)
         state_d = S_RD;
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
      sp_d       = sp_q;
      code_d     = code_q;
      rd_d       = rd_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      ram_addr   = sp_q[SW-1:0];
      ram_wdata  = '0;
      if (accept) begin
         code_d = cmd.op_code;
         rd_d   = cmd.op_rd;
         if (fault) begin
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = illegal ? 2'd3 : (underflow ? 2'd1 : 2'd2);
         end else begin
            done_d     = !stack_rd_op;
            err_code_d = stack_rd_op ? err_code_q : 2'd0;
            case (cmd.op_code)
               OP_MOVI: regs_d[cmd.op_rd] = cmd.op_imm;
               OP_PUSH: begin
                  ram_we                = 1'b1;
                  ram_wdata             = regs_q[cmd.op_rs];
                  regs_d[cmd.op_rs]     = '0;
                  sp_d                  = sp_q + 1'b1;
               end
               OP_RCOPY: regs_d[cmd.op_rd] = regs_q[cmd.op_rs];
               // Clear is applied last so rd == rs ends up zero.
               OP_RMOV: begin
                  regs_d[cmd.op_rd] = regs_q[cmd.op_rs];
                  regs_d[cmd.op_rs] = '0;
               end
`ifdef MICROM_REGSTACK_SWAP_EN
               OP_POP, OP_DUP, OP_SWAP: begin
`else
               OP_POP, OP_DUP: begin
`endif
                  ram_re   = 1'b1;
                  ram_addr = sp_m1[SW-1:0];
               end
               default: ;
            endcase
         end
      end else if (state_q == S_RD) begin
         done_d     = 1'b1;
         err_code_d = 2'd0;
         case (code_q)
            OP_POP: begin
               regs_d[rd_q] = ram_rdata_q;
               sp_d         = sp_m1;
            end
            OP_DUP: begin
               ram_we    = 1'b1;
               ram_wdata = ram_rdata_q;
               sp_d      = sp_q + 1'b1;
            end
`ifdef MICROM_REGSTACK_SWAP_EN
            OP_SWAP: begin
               regs_d[rd_q] = ram_rdata_q;
               ram_we       = 1'b1;
               ram_addr     = sp_m1[SW-1:0];
               ram_wdata    = regs_q[rd_q];
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      cmd.op_ready = (state_q == S_IDLE);
      cmd.done     = done_q;
      cmd.err      = err_q;
      cmd.err_code = err_code_q;
      sp           = sp_q;
      rd_data      = regs_q[rd_addr];
   end
endmodule

// File: tb/tb_microm_regstack_unit.sv
// Scoreboard bench for microm_regstack_unit: a behavioural model queues the
// expected retirement of each command, compared when done pulses.
module tb_microm_regstack_unit;
   localparam bit SWAP =
`ifdef MICROM_REGSTACK_SWAP_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic [4:0]  sp;

   microm_regstack_unit_if #(.WIDTH(32), .RW(3)) cmd_if ();

   microm_regstack_unit #(.WIDTH(32), .NREG(8), .DEPTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cmd     (cmd_if),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .sp      (sp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          lat;
      logic        err;
      logic [1:0]  code;
      logic [4:0]  sp;
      logic [2:0]  idx;
      logic [31:0] val;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mregs [8];
   logic [31:0] mstk [16];
   int          msp;
   int          n_vec = 0;
   int          n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      msp = 0;
      sbq.delete();
   endtask

   // Reference semantics; pushes what the DUT must report at retirement.
   task automatic model(input string tag, input logic [3:0] code, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [31:0] imm);
      exp_t e;
      logic srd, und, ovf, ill;
      logic [31:0] tmp;
      srd = (code == 3) || (code == 4) || ((code == 7) && SWAP);
      und = srd && (msp == 0);
      ovf = ((code == 2) || (code == 4)) && (msp == 16);
      ill = (code >= 8) || ((code == 7) && !SWAP);
      e.tag = tag; e.lat = 1; e.err = 1'b0; e.code = 2'd0; e.idx = rd;
      if (ill)      begin e.err = 1'b1; e.code = 2'd3; end
      else if (und) begin e.err = 1'b1; e.code = 2'd1; end
      else if (ovf) begin e.err = 1'b1; e.code = 2'd2; end
      else begin
         case (code)
            1: mregs[rd] = imm;
            2: begin mstk[msp] = mregs[rs]; mregs[rs] = '0; msp++; e.idx = rs; end
            3: begin mregs[rd] = mstk[msp-1]; msp--; e.lat = 2; end
            4: begin mstk[msp] = mstk[msp-1]; msp++; e.lat = 2; end
            5: mregs[rd] = mregs[rs];
            6: begin tmp = mregs[rs]; mregs[rd] = tmp; mregs[rs] = '0; end
            7: begin tmp = mregs[rd]; mregs[rd] = mstk[msp-1]; mstk[msp-1] = tmp; e.lat = 2; end
            default: ;
         endcase
      end
      e.sp  = 5'(msp);
      e.val = mregs[e.idx];
      sbq.push_back(e);
   endtask

   task automatic retire(input int cyc);
      exp_t e;
      e = sbq.pop_front();
      $display("op %-10s lat=%0d err=%0b code=%0d sp=%0d r%0d=0x%0h",
               e.tag, cyc, cmd_if.err, cmd_if.err_code, sp, e.idx, rd_data);
      chk({e.tag, ".lat"}, 32'(cyc), 32'(e.lat));
      chk({e.tag, ".err"}, 32'(cmd_if.err), 32'(e.err));
      chk({e.tag, ".err_code"}, 32'(cmd_if.err_code), 32'(e.code));
      chk({e.tag, ".sp"}, 32'(sp), 32'(e.sp));
      rd_addr = e.idx;
      #1;
      chk({e.tag, ".reg"}, rd_data, e.val);
   endtask

   task automatic drive(input logic [3:0] code, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [31:0] imm);
      cmd_if.op_code = code; cmd_if.op_rd = rd; cmd_if.op_rs = rs; cmd_if.op_imm = imm;
      cmd_if.op_valid = 1'b1;
   endtask

   task automatic do_op(input string tag, input logic [3:0] code, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [31:0] imm);
      bit got;
      @(negedge clk);
      chk({tag, ".ready"}, 32'(cmd_if.op_ready), 32'd1);
      model(tag, code, rd, rs, imm);
      drive(code, rd, rs, imm);
      @(posedge clk);
      #1 cmd_if.op_valid = 1'b0;
      got = 1'b0;
      for (int c = 1; c <= 4 && !got; c++) begin
         @(negedge clk);
         if (cmd_if.done) begin
            got = 1'b1;
            retire(c);
         end else begin
            chk({tag, ".busy_ready"}, 32'(cmd_if.op_ready), 32'd0);
         end
      end
      if (!got) begin
         chk({tag, ".done_timeout"}, 32'd0, 32'd1);
         void'(sbq.pop_front());
      end
   endtask

   task automatic check_reg(input logic [2:0] idx);
      @(negedge clk);
      rd_addr = idx;
      #1;
      chk($sformatf("reg_r%0d", idx), rd_data, mregs[idx]);
   endtask

   initial begin
      cmd_if.op_valid = 1'b0; cmd_if.op_code = '0; cmd_if.op_rd = '0;
      cmd_if.op_rs = '0; cmd_if.op_imm = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst.ready", 32'(cmd_if.op_ready), 32'd1);
      chk("rst.done", 32'(cmd_if.done), 32'd0);
      chk("rst.err", 32'(cmd_if.err), 32'd0);
      chk("rst.err_code", 32'(cmd_if.err_code), 32'd0);
      chk("rst.sp", 32'(sp), 32'd0);
      rst_n = 1'b1;

      do_op("movi_r3", 4'd1, 3'd3, 3'd0, 32'h1234);
      do_op("movi_r1", 4'd1, 3'd1, 3'd0, 32'd5);
      do_op("push_r1", 4'd2, 3'd0, 3'd1, 32'd0);
      do_op("pop_r2", 4'd3, 3'd2, 3'd0, 32'd0);

      do_op("movi_r0", 4'd1, 3'd0, 3'd0, 32'h3c);
      do_op("pop_empty", 4'd3, 3'd0, 3'd0, 32'd0);

      for (int i = 0; i < 16; i++) begin
         do_op("fill_movi", 4'd1, 3'd1, 3'd0, 32'h100 + 32'(i));
         do_op("fill_push", 4'd2, 3'd0, 3'd1, 32'd0);
      end
      do_op("dup_full", 4'd4, 3'd2, 3'd0, 32'd0);
      do_op("movi_r1", 4'd1, 3'd1, 3'd0, 32'hbeef);
      do_op("push_full", 4'd2, 3'd0, 3'd1, 32'd0);
      for (int i = 0; i < 16; i++) do_op("drain_pop", 4'd3, 3'd2, 3'd0, 32'd0);

      do_op("movi_r4", 4'd1, 3'd4, 3'd0, 32'd9);
      do_op("rmov_r4r5", 4'd6, 3'd5, 3'd4, 32'd0);
      check_reg(3'd4);
      do_op("movi_r6", 4'd1, 3'd6, 3'd0, 32'd7);
      do_op("rmov_r6r6", 4'd6, 3'd6, 3'd6, 32'd0);
      do_op("rcopy_r5r7", 4'd5, 3'd7, 3'd5, 32'd0);
      check_reg(3'd5);

      do_op("movi_aa", 4'd1, 3'd1, 3'd0, 32'hAA);
      do_op("push_aa", 4'd2, 3'd0, 3'd1, 32'd0);
      do_op("dup", 4'd4, 3'd0, 3'd0, 32'd0);
      do_op("movi_55", 4'd1, 3'd1, 3'd0, 32'h55);
      do_op("swap_r1", 4'd7, 3'd1, 3'd0, 32'd0);
      do_op("pop_top", 4'd3, 3'd2, 3'd0, 32'd0);
      do_op("pop_next", 4'd3, 3'd3, 3'd0, 32'd0);
      do_op("illegal_12", 4'd12, 3'd3, 3'd0, 32'd0);

      // Back-to-back: RCOPY accepted the cycle after MOVI must see its result.
      @(negedge clk);
      model("b2b_movi", 4'd1, 3'd2, 3'd0, 32'h77);
      drive(4'd1, 3'd2, 3'd0, 32'h77);
      @(posedge clk);
      #1;
      model("b2b_rcopy", 4'd5, 3'd3, 3'd2, 32'd0);
      drive(4'd5, 3'd3, 3'd2, 32'd0);
      @(negedge clk);
      chk("b2b_movi.done", 32'(cmd_if.done), 32'd1);
      retire(1);
      @(posedge clk);
      #1 cmd_if.op_valid = 1'b0;
      @(negedge clk);
      chk("b2b_rcopy.done", 32'(cmd_if.done), 32'd1);
      retire(1);

      // Reset while a POP sits in its RAM-read cycle.
      do_op("movi_r4", 4'd1, 3'd4, 3'd0, 32'h44);
      do_op("push_r4", 4'd2, 3'd0, 3'd4, 32'd0);
      @(negedge clk);
      drive(4'd3, 3'd2, 3'd0, 32'd0);
      @(posedge clk);
      #1 cmd_if.op_valid = 1'b0;
      @(negedge clk);
      chk("rd.ready", 32'(cmd_if.op_ready), 32'd0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("abort.ready", 32'(cmd_if.op_ready), 32'd1);
      chk("abort.sp", 32'(sp), 32'd0);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         chk($sformatf("abort.r%0d", i), rd_data, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort.no_done", 32'(cmd_if.done), 32'd0);
      end
      do_op("post_movi", 4'd1, 3'd6, 3'd0, 32'h600d);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/microm_regstack_unit.md
Name: microm_regstack_unit

Overview:
- Hardware execution unit for the microm register/stack instruction group: an integer register file plus a hardware operand stack with a single-port registered-read stack RAM.
- Generalises the software VM semantics (mov, push-and-clear, pop-to-register, dup, register copy/move) to parametrised width, register count and stack depth.
- Adds a valid/ready command handshake, overflow/underflow/illegal-op detection and a multi-cycle sequencer.
- Sits between the microm instruction decoder and the ALU, which reads registers through a combinational read port.

Parameters:
- WIDTH, 32, data width of registers and stack entries.
- NREG, 8, number of registers (power of two, >=2); RW = log2(NREG).
- DEPTH, 16, stack entries (power of two, >=2); SW = log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  command valid.
- op_ready  out  1  unit can accept a command.
- op_code  in  4  opcode: 0 NOP, 1 MOVI, 2 PUSH, 3 POP, 4 DUP, 5 RCOPY, 6 RMOV, 7 SWAP; 8-15 illegal.
- op_rd  in  RW  destination register.
- op_rs  in  RW  source register.
- op_imm  in  WIDTH  immediate for MOVI.
- rd_addr  in  RW  ALU read address.
- rd_data  out  WIDTH  combinational read of reg[rd_addr].
- sp  out  SW+1  stack occupancy, 0..DEPTH.
- done  out  1  one-cycle pulse, command retired.
- err  out  1  one-cycle pulse, command faulted (coincident with done).
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 illegal; held until next retirement.

Behaviour:
- Reset (async, rst_n low): all registers 0, sp 0, state IDLE, op_ready 1, done 0, err 0, err_code 0. Stack RAM contents are not reset. Reset mid-operation aborts the command; no partial write survives.
- Handshake: a command is accepted on a rising edge with op_valid && op_ready. op_ready = (state == IDLE). op_* is sampled only at acceptance.
- States:
  - IDLE: accepts commands.
  - RD: stack RAM read data is valid.
  - IDLE -> RD for POP/DUP/SWAP without fault.
  - RD -> IDLE always, after one cycle.
- 1-cycle ops: architectural update on the accept edge; done high the following cycle.
  - MOVI: reg[rd] = op_imm.
  - PUSH: mem[sp] = reg[rs]; reg[rs] = 0; sp += 1.
  - RCOPY: reg[rd] = reg[rs].
  - RMOV: reg[rd] = reg[rs], then reg[rs] = 0. The clear wins, so rd == rs yields 0.
  - NOP: done only.
- 2-cycle ops: accept edge issues RAM read of mem[sp-1]; update on the RD-exit edge; done the cycle after.
  - POP: reg[rd] = top; sp -= 1.
  - DUP: mem[sp] = top; sp += 1.
  - SWAP: see Optional Feature.
- Faults: no state change; done and err both pulse one cycle after the accept edge (faulted ops always take 1 cycle).
  - POP/DUP/SWAP with sp == 0: underflow.
  - PUSH/DUP with sp == DEPTH: overflow.
  - op_code 8-15: illegal.
- Register 0 is an ordinary register (not hardwired to zero).
- rd_data is the current register value; updates are visible the cycle after the writing edge. No bypass.
- Back-to-back: a 1-cycle op may be accepted every cycle. A second command sees the first's results.

Optional Feature:
- Macro: MICROM_REGSTACK_SWAP_EN.
- Defined: SWAP (7) is a 2-cycle op that exchanges reg[rd] and the top of stack; sp unchanged; underflow if sp == 0.
- Undefined: op_code 7 is illegal (err_code 3), and no swap datapath is built.

Test Plan:
- Reset, then MOVI r3 = 0x1234 -> done one cycle later; rd_addr = 3 reads 0x1234; sp = 0; err = 0.
- MOVI r1 = 5; PUSH r1; POP r2 -> after PUSH r1 = 0 and sp = 1; POP holds op_ready low one cycle; then r2 = 5 and sp = 0.
- Empty stack: POP r0 -> err = 1, err_code = 1, r0 unchanged. Fill to DEPTH = 16 with PUSH, then DUP -> err_code = 2, sp stays 16.
- MOVI r4 = 9; RMOV r4 -> r5 gives r5 = 9, r4 = 0. RMOV r6 -> r6 with r6 = 7 gives r6 = 0. RCOPY r5 -> r7 leaves both at 9.
- PUSH 0xAA; DUP; then SWAP with r1 = 0x55 -> with macro: r1 = 0xAA, top = 0x55, sp = 2. Without macro: err_code = 3, no state change.
- Assert rst_n low during RD of a POP -> sp = 0, all registers 0, op_ready = 1 immediately; no done pulse after release.
